// File: rtl/popcount_expander.sv
// Builds a WIDTH-bit word with the lowest N bits set. The word is shifted out
// LSB-first, one bit per clock, and is also presented in parallel, using a
// level-held start / sticky done handshake.
module popcount_expander #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CW-1:0]    count_in,
  output logic [WIDTH-1:0] data_out,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] MAX_COUNT = CW'(WIDTH);
  localparam logic [CW-1:0] LAST_IDX  = CW'(WIDTH - 1);

  logic [1:0]    state;
  logic [CW-1:0] remaining;
  logic [CW-1:0] idx;
  logic          over;
  logic [CW-1:0] sat_count;
  logic          fill_bit;

  // Requests above WIDTH saturate to an all-ones word and raise err.
  assign over      = (count_in > MAX_COUNT);
  assign sat_count = over ? MAX_COUNT : count_in;
  // Ones are emitted while any remain, so the set bits land at the LSB end.
  assign fill_bit  = (remaining != '0);

  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      data_out  <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      err       <= 1'b0;
      remaining <= '0;
      idx       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          data_out  <= '0;
          bit_out   <= 1'b0;
          bit_valid <= 1'b0;
          if (start) begin
            remaining <= sat_count;
            err       <= over;
            idx       <= '0;
            state     <= S_FILL;
          end else begin
            err <= 1'b0;
          end
        end

        S_FILL: begin
          if (!start) begin
            state     <= S_IDLE;
            data_out  <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            err       <= 1'b0;
            remaining <= '0;
            idx       <= '0;
          end else begin
            data_out  <= {fill_bit, data_out[WIDTH-1:1]};
            bit_out   <= fill_bit;
            bit_valid <= 1'b1;
            if (fill_bit)
              remaining <= remaining - 1'b1;
            // idx wraps to 0 on the final shift so it never exceeds WIDTH-1.
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= S_DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        S_DONE: begin
          bit_out   <= 1'b0;
          bit_valid <= 1'b0;
          if (!start) begin
            state    <= S_IDLE;
            data_out <= '0;
            err      <= 1'b0;
          end
        end

        default: begin
          state     <= S_IDLE;
          data_out  <= '0;
          bit_out   <= 1'b0;
          bit_valid <= 1'b0;
          err       <= 1'b0;
          remaining <= '0;
          idx       <= '0;
        end
      endcase
    end
  end

endmodule
